// File: rtl/cache_types_pkg.sv
// Shared types and default geometry for the cache line <-> memory bus burst adapter.
package cache_types;

  localparam int unsigned DEF_LINE_BITS = 256;
  localparam int unsigned DEF_BUS_BITS  = 64;
  localparam int unsigned DEF_ADDR_BITS = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRAIN = 2'd2,
    WR_BURST = 2'd3
  } adapter_state_t;

endpackage

// File: rtl/burst_line_buffer.sv
// BEATS x BUS_BITS slot array shared by the fill path (per-slot writes) and the
// writeback path (full-line load, per-beat read-out).
module burst_line_buffer #(
  parameter int unsigned BEATS    = 4,
  parameter int unsigned BUS_BITS = 64,
  localparam int unsigned IDX_W   = $clog2(BEATS)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_load,
  input  logic [BEATS*BUS_BITS-1:0]       i_line,
  input  logic                            i_wr_en,
  input  logic [IDX_W-1:0]                i_wr_slot,
  input  logic [BUS_BITS-1:0]             i_wr_data,
  input  logic [IDX_W-1:0]                i_rd_slot,
  output logic [BUS_BITS-1:0]             o_rd_data,
  output logic [(BEATS-1)*BUS_BITS-1:0]   o_fill_prefix
);

  logic [BUS_BITS-1:0] r_slots [BEATS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(BEATS); i++) begin
        r_slots[i] <= '0;
      end
    end else if (i_load) begin
      for (int i = 0; i < int'(BEATS); i++) begin
        r_slots[i] <= i_line[i*BUS_BITS +: BUS_BITS];
      end
    end else if (i_wr_en) begin
      r_slots[i_wr_slot] <= i_wr_data;
    end
  end

  assign o_rd_data = r_slots[i_rd_slot];

  // The last slot never feeds the fill response: the final beat bypasses straight from the bus.
  always_comb begin
    o_fill_prefix = '0;
    for (int i = 0; i < int'(BEATS) - 1; i++) begin
      o_fill_prefix[i*BUS_BITS +: BUS_BITS] = r_slots[i];
    end
  end

endmodule

// File: rtl/burst_cache_adapter.sv
// Cache line <-> memory bus burst adapter: splits writebacks into beats, coalesces
// tagged read beats into a line, and drains squashed reads instead of aborting them.
//
// state    | meaning
// IDLE     | no burst outstanding; read request wins over write
// RD_WAIT  | fill burst issued, collecting beats tagged with the latched address
// RD_DRAIN | fill squashed by a mispredict; swallowing its remaining beats
// WR_BURST | writeback in progress, beat 0 already accepted
module burst_cache_adapter
  import cache_types::*;
#(
  parameter int unsigned LINE_BITS = DEF_LINE_BITS,
  parameter int unsigned BUS_BITS  = DEF_BUS_BITS,
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [ADDR_BITS-1:0] i_cache_addr,
  input  logic                 i_cache_read,
  input  logic                 i_cache_write,
  input  logic [LINE_BITS-1:0] i_cache_wdata,
  output logic [LINE_BITS-1:0] o_cache_rdata,
  output logic                 o_cache_resp,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [BUS_BITS-1:0]  o_mem_wdata,
  input  logic                 i_mem_ready,
  input  logic [BUS_BITS-1:0]  i_mem_rdata,
  input  logic [ADDR_BITS-1:0] i_mem_raddr,
  input  logic                 i_mem_rvalid,
  output logic                 o_request,
  output logic                 o_write_complete,
  input  logic                 i_branch_mispredict
);

  localparam int unsigned BEATS = LINE_BITS / BUS_BITS;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_BITS-1:0] OFFS_MASK = ADDR_BITS'(LINE_BITS / 8 - 1);

  adapter_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_beat_cnt, w_beat_cnt_nxt;
  logic [ADDR_BITS-1:0]   r_addr, w_addr_nxt;
  logic [ADDR_BITS-1:0]   w_addr_aligned;
  logic                   w_match;
  logic                   w_last_beat;
  logic                   w_buf_load;
  logic                   w_buf_wr_en;
  logic [BUS_BITS-1:0]    w_buf_rd_data;
  logic [LINE_BITS-BUS_BITS-1:0] w_fill_prefix;

  assign w_addr_aligned = i_cache_addr & ~OFFS_MASK;
  assign w_match        = i_mem_rvalid && (i_mem_raddr == r_addr);
  assign w_last_beat    = (r_beat_cnt == LAST_BEAT);
  assign o_request      = i_cache_read | i_cache_write;
  assign o_cache_rdata  = {i_mem_rdata, w_fill_prefix};

  burst_line_buffer #(
    .BEATS    (BEATS),
    .BUS_BITS (BUS_BITS)
  ) u_line_buf (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load        (w_buf_load),
    .i_line        (i_cache_wdata),
    .i_wr_en       (w_buf_wr_en),
    .i_wr_slot     (r_beat_cnt),
    .i_wr_data     (i_mem_rdata),
    .i_rd_slot     (r_beat_cnt),
    .o_rd_data     (w_buf_rd_data),
    .o_fill_prefix (w_fill_prefix)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_addr_nxt       = r_addr;
    w_buf_load       = 1'b0;
    w_buf_wr_en      = 1'b0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_cache_resp     = 1'b0;
    o_write_complete = 1'b0;
    o_mem_addr       = r_addr;
    o_mem_wdata      = w_buf_rd_data;

    case (r_state)
      IDLE: begin
        o_mem_addr  = w_addr_aligned;
        o_mem_wdata = i_cache_wdata[BUS_BITS-1:0];
        if (i_cache_read) begin
          o_mem_read = ~i_branch_mispredict;
          if (!i_branch_mispredict && i_mem_ready) begin
            w_addr_nxt     = w_addr_aligned;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = RD_WAIT;
          end
        end else if (i_cache_write && !i_branch_mispredict) begin
          o_mem_write = 1'b1;
          // Beat 0 goes straight from the cache port; the buffer serves the rest.
          if (i_mem_ready) begin
            w_buf_load     = 1'b1;
            w_addr_nxt     = w_addr_aligned;
            w_beat_cnt_nxt = CNT_W'(1);
            w_state_nxt    = WR_BURST;
          end
        end
      end

      WR_BURST: begin
        o_mem_write = 1'b1;
        if (i_mem_ready) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (w_last_beat) begin
            o_cache_resp     = 1'b1;
            o_write_complete = 1'b1;
            w_state_nxt      = IDLE;
          end
        end
      end

      RD_WAIT: begin
        if (w_match) begin
          w_buf_wr_en    = 1'b1;
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
        if (w_match && w_last_beat) begin
          o_cache_resp = ~i_branch_mispredict;
          w_state_nxt  = IDLE;
        end else if (i_branch_mispredict) begin
          w_state_nxt = RD_DRAIN;
        end
      end

      RD_DRAIN: begin
        if (w_match) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          if (w_last_beat) begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (i_rst) begin
      o_mem_read       = 1'b0;
      o_mem_write      = 1'b0;
      o_cache_resp     = 1'b0;
      o_write_complete = 1'b0;
    end
  end

endmodule
